// File: rtl/aud_rmm_arb.sv
// Round-robin sequencer sharing one aud_rmm engine among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining AUD_RMM_ARB_TIMEOUT_EN.

module aud_rmm_arb_lane #(
  parameter int IW   = 2,
  parameter int LANE = 0
) (
  input  logic          aud_ck,
  input  logic          rst_n,
  input  logic          resp_d,
  input  logic [IW-1:0] gnt_d,
  output logic          done
);
  logic done_d, done_q;

  always_comb done_d = resp_d && (gnt_d == IW'(LANE));

  always_ff @(posedge aud_ck or negedge rst_n)
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= done_d;

  assign done = done_q;
endmodule

module aud_rmm_arb #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     aud_ck,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_we,
  input  logic [NUM_REQ-1:0][1:0]  req_size,
  input  logic [NUM_REQ-1:0][31:0] req_addr,
  input  logic [NUM_REQ-1:0][31:0] req_wdata,
  output logic [NUM_REQ-1:0]       req_done,
  output logic                     req_err,
  output logic [31:0]              req_rdata,
  output logic                     busy,
  output logic                     rmm_rst,
  output logic                     rmm_we,
  output logic                     rmm_re,
  output logic [1:0]               rmm_size,
  output logic [31:0]              rmm_addr,
  output logic [31:0]              rmm_wdata,
  output logic                     rmm_data_oe,
  input  logic [31:0]              rmm_rdata,
  input  logic                     rmm_done,
  input  logic                     rmm_err
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state_d, state_q;
  logic [IW-1:0] rr_ptr_d, rr_ptr_q;
  logic [IW-1:0] gnt_d, gnt_q;
  logic          we_d, we_q;
  logic [1:0]    size_d, size_q;
  logic [31:0]   addr_d, addr_q;
  logic [31:0]   wdata_d, wdata_q;
  logic          err_d, err_q;
  logic [31:0]   rdata_d, rdata_q;
  logic          rmm_we_d, rmm_we_q;
  logic          rmm_re_d, rmm_re_q;
  logic          oe_d, oe_q;
  logic          busy_d, busy_q;
  logic          resp_d;

  logic          found;
  logic [IW-1:0] win, cand;

  // Scan starts one past the last winner, so the last winner is lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

`ifdef AUD_RMM_ARB_TIMEOUT_EN
  logic [15:0] wcnt_d, wcnt_q;
  logic        abort_d, abort_q;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    rmm_we_d = 1'b0;
    rmm_re_d = 1'b0;
    oe_d     = 1'b0;
`ifdef AUD_RMM_ARB_TIMEOUT_EN
    wcnt_d   = wcnt_q;
    abort_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (found) begin
        gnt_d   = win;
        we_d    = req_we[win];
        size_d  = req_size[win];
        addr_d  = req_addr[win];
        wdata_d = req_wdata[win];
        if (req_size[win] == 2'd3) begin
          // Illegal size never reaches the engine.
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          state_d  = S_ISSUE;
          rmm_we_d = req_we[win];
          rmm_re_d = ~req_we[win];
          oe_d     = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef AUD_RMM_ARB_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      S_WAIT: begin
        if (rmm_done) begin
          state_d = S_RESP;
          err_d   = rmm_err;
          rdata_d = we_q ? 32'd0 : rmm_rdata;
        end
`ifdef AUD_RMM_ARB_TIMEOUT_EN
        else if (wcnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
          abort_d = 1'b1;
        end else begin
          wcnt_d  = wcnt_q + 16'd1;
        end
`endif
      end
      default: begin
        rr_ptr_d = gnt_q;
        state_d  = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    resp_d = (state_d == S_RESP);
  end

  always_ff @(posedge aud_ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= IW'(NUM_REQ - 1);
      gnt_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rmm_we_q <= 1'b0;
      rmm_re_q <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rmm_we_q <= rmm_we_d;
      rmm_re_q <= rmm_re_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
    end
  end

`ifdef AUD_RMM_ARB_TIMEOUT_EN
  always_ff @(posedge aud_ck or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      abort_q <= abort_d;
    end
  end
  assign rmm_rst = ~rst_n | abort_q;
`else
  assign rmm_rst = ~rst_n;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    aud_rmm_arb_lane #(.IW(IW), .LANE(g)) u_lane (
      .aud_ck (aud_ck),
      .rst_n  (rst_n),
      .resp_d (resp_d),
      .gnt_d  (gnt_d),
      .done   (req_done[g])
    );
  end

  assign req_err     = err_q;
  assign req_rdata   = rdata_q;
  assign busy        = busy_q;
  assign rmm_we      = rmm_we_q;
  assign rmm_re      = rmm_re_q;
  assign rmm_size    = size_q;
  assign rmm_addr    = addr_q;
  assign rmm_wdata   = wdata_q;
  assign rmm_data_oe = oe_q;
endmodule

// File: tb/tb_aud_rmm_arb.sv
// Randomized scoreboard bench for aud_rmm_arb with a behavioural engine and rotation model.
module tb_aud_rmm_arb;
  localparam int N  = 4;
  localparam int TO = 16;

  logic              aud_ck = 1'b0;
  logic              rst_n  = 1'b0;
  logic [N-1:0]      req_valid, req_we;
  logic [N-1:0][1:0] req_size;
  logic [N-1:0][31:0] req_addr, req_wdata;
  logic [N-1:0]      req_done;
  logic              req_err, busy, rmm_rst, rmm_we, rmm_re, rmm_data_oe;
  logic [31:0]       req_rdata, rmm_addr, rmm_wdata, rmm_rdata;
  logic [1:0]        rmm_size;
  logic              rmm_done, rmm_err;

  aud_rmm_arb #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .aud_ck(aud_ck), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata), .busy(busy),
    .rmm_rst(rmm_rst), .rmm_we(rmm_we), .rmm_re(rmm_re), .rmm_size(rmm_size),
    .rmm_addr(rmm_addr), .rmm_wdata(rmm_wdata), .rmm_data_oe(rmm_data_oe),
    .rmm_rdata(rmm_rdata), .rmm_done(rmm_done), .rmm_err(rmm_err)
  );

  always #5 aud_ck = ~aud_ck;

  typedef struct { int idx; logic err; logic [31:0] rdata; bit chk_rd; bit abort; } exp_t;
  typedef struct { logic we; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
  typedef struct { logic [31:0] rdata; logic err; int dly; } eng_t;

  exp_t exp_q[$];
  cmd_t cmd_q[$];
  eng_t eng_q[$];
  int   n_chk = 0, n_fail = 0;
  int   ptr   = N - 1;

  logic        f_we[N];
  logic [1:0]  f_size[N];
  logic [31:0] f_addr[N], f_wdata[N], e_rdata[N];
  logic        e_err[N];
  int          e_dly[N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] zext(input logic [31:0] v, input logic [1:0] sz);
    case (sz)
      2'd0:    return v & 32'h0000_00FF;
      2'd1:    return v & 32'h0000_FFFF;
      default: return v;
    endcase
  endfunction

  task automatic rand_fields(input int i);
    f_we[i]    = 1'($urandom_range(0, 1));
    f_size[i]  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    f_addr[i]  = $urandom;
    f_wdata[i] = $urandom;
    e_rdata[i] = zext($urandom, f_size[i]);
    e_err[i]   = ($urandom_range(0, 3) == 0);
    e_dly[i]   = $urandom_range(0, 4);
  endtask

  // Scoreboard monitor: every req_done pulse must match the next expected completion.
  exp_t mon_e;
  logic [N-1:0] mon_v;
  always @(negedge aud_ck) begin
    if (rst_n && req_done != '0) begin
      if (exp_q.size() == 0) chk("unexpected_done", 64'(req_done), 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        mon_v = '0;
        mon_v[mon_e.idx] = 1'b1;
        chk("done_vec", 64'(req_done), 64'(mon_v));
        chk("done_err", 64'(req_err), 64'(mon_e.err));
        if (mon_e.chk_rd) chk("done_rdata", 64'(req_rdata), 64'(mon_e.rdata));
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_rmm_rst", 64'(rmm_rst), 64'(mon_e.abort));
      end
    end
  end

  // Behavioural engine: checks each command, then answers after its scheduled delay.
  cmd_t eng_c;
  eng_t eng_r;
  initial begin
    rmm_done = 1'b0; rmm_err = 1'b0; rmm_rdata = '0;
    forever begin
      @(negedge aud_ck);
      rmm_rdata = $urandom; rmm_err = 1'($urandom_range(0, 1));
      if (rst_n && (rmm_we || rmm_re)) begin
        if (cmd_q.size() == 0 || eng_q.size() == 0)
          chk("unexpected_cmd", 64'({rmm_we, rmm_re}), 64'd0);
        else begin
          eng_c = cmd_q.pop_front();
          eng_r = eng_q.pop_front();
          chk("cmd_we", 64'(rmm_we), 64'(eng_c.we));
          chk("cmd_re", 64'(rmm_re), 64'(!eng_c.we));
          chk("cmd_oe", 64'(rmm_data_oe), 64'd1);
          chk("cmd_size", 64'(rmm_size), 64'(eng_c.size));
          chk("cmd_addr", 64'(rmm_addr), 64'(eng_c.addr));
          chk("cmd_wdata", 64'(rmm_wdata), 64'(eng_c.wdata));
          @(negedge aud_ck);
          rmm_rdata = $urandom;
          chk("strobe_one_cycle", 64'({rmm_we, rmm_re, rmm_data_oe}), 64'd0);
          if (eng_r.dly >= 0) begin
            repeat (eng_r.dly) begin @(negedge aud_ck); rmm_rdata = $urandom; end
            rmm_done = 1'b1; rmm_err = eng_r.err; rmm_rdata = eng_r.rdata;
            @(negedge aud_ck);
            rmm_done = 1'b0; rmm_rdata = $urandom;
          end
        end
      end
    end
  end

  // Serve every requester in mask; service order follows the rotation from the last winner.
  task automatic run_round(input logic [N-1:0] mask);
    int   order[$];
    int   k, cnt, cyc, lat_exp;
    exp_t e;
    cmd_t c;
    eng_t r;
    lat_exp = 0;
    for (int s = 1; s <= N; s++) begin
      k = (ptr + s) % N;
      if (mask[k]) order.push_back(k);
    end
    foreach (order[j]) begin
      k = order[j];
      e.idx = k; e.abort = 1'b0;
      if (f_size[k] == 2'd3) begin
        e.err = 1'b1; e.rdata = '0; e.chk_rd = 1'b0; lat_exp = 1;
      end else begin
        c = '{f_we[k], f_size[k], f_addr[k], f_wdata[k]};
        r = '{e_rdata[k], e_err[k], e_dly[k]};
        cmd_q.push_back(c);
        eng_q.push_back(r);
        e.chk_rd = 1'b1;
        if (e_dly[k] < 0) begin
          e.err = 1'b1; e.rdata = '0; e.abort = 1'b1; lat_exp = 2 + TO;
        end else begin
          e.err = e_err[k]; e.rdata = f_we[k] ? 32'd0 : e_rdata[k]; lat_exp = 3 + e_dly[k];
        end
      end
      exp_q.push_back(e);
    end
    ptr = order[order.size() - 1];
    @(negedge aud_ck);
    for (int i = 0; i < N; i++) begin
      req_we[i] = f_we[i]; req_size[i] = f_size[i];
      req_addr[i] = f_addr[i]; req_wdata[i] = f_wdata[i];
    end
    req_valid = mask;
    cnt = 0; cyc = 0;
    while (cnt < order.size() && cyc < 300) begin
      @(negedge aud_ck);
      cyc++;
      for (int i = 0; i < N; i++)
        if (req_done[i]) begin
          req_valid[i] = 1'b0;
          cnt++;
          if (order.size() == 1) chk("latency", 64'(cyc), 64'(lat_exp));
        end
    end
    if (cnt < order.size()) begin
      chk("round_timeout", 64'(cnt), 64'(order.size()));
      req_valid = '0;
      exp_q.delete(); cmd_q.delete(); eng_q.delete();
    end
  endtask

  initial begin
    req_valid = '0; req_we = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge aud_ck);
    chk("rst_rmm_rst", 64'(rmm_rst), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(req_done), 64'd0);
    chk("rst_we_re_oe", 64'({rmm_we, rmm_re, rmm_data_oe}), 64'd0);
    chk("rst_err", 64'(req_err), 64'd0);
    chk("rst_rdata", 64'(req_rdata), 64'd0);
    chk("rst_addr", 64'(rmm_addr), 64'd0);
    rst_n = 1'b1;

    // Fairness: everybody requests, two full rounds.
    for (int i = 0; i < N; i++) rand_fields(i);
    run_round(4'b1111);
    for (int i = 0; i < N; i++) rand_fields(i);
    run_round(4'b1111);

    // Single long write.
    f_we[0] = 1'b1; f_size[0] = 2'd2; f_addr[0] = 32'h0000_1000; f_wdata[0] = 32'hDEAD_BEEF;
    e_rdata[0] = 32'h1111_2222; e_err[0] = 1'b0; e_dly[0] = 1;
    run_round(4'b0001);

    // Word read.
    f_we[2] = 1'b0; f_size[2] = 2'd1; f_addr[2] = 32'hFFFF_8000; f_wdata[2] = 32'h0;
    e_rdata[2] = 32'h0000_1234; e_err[2] = 1'b0; e_dly[2] = 2;
    run_round(4'b0100);

    // Illegal size.
    f_we[1] = 1'b0; f_size[1] = 2'd3; f_addr[1] = 32'hA5A5_0000;
    run_round(4'b0010);

    // Engine error on a read.
    f_we[3] = 1'b0; f_size[3] = 2'd0; f_addr[3] = 32'h40; e_rdata[3] = 32'h7E;
    e_err[3] = 1'b1; e_dly[3] = 0;
    run_round(4'b1000);

    // Reset while waiting on the engine: no completion may follow.
    cmd_q.push_back('{1'b0, 2'd2, 32'h0000_2000, 32'h0BAD_F00D});
    eng_q.push_back('{32'h0000_0055, 1'b0, 20});
    @(negedge aud_ck);
    req_we[1] = 1'b0; req_size[1] = 2'd2; req_addr[1] = 32'h0000_2000;
    req_wdata[1] = 32'h0BAD_F00D; req_valid = 4'b0010;
    repeat (4) @(negedge aud_ck);
    chk("wait_busy", 64'(busy), 64'd1);
    rst_n = 1'b0; req_valid = '0;
    #1;
    chk("midrst_rmm_rst", 64'(rmm_rst), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(req_done), 64'd0);
    @(negedge aud_ck);
    rst_n = 1'b1;
    #1;
    chk("postrst_rmm_rst", 64'(rmm_rst), 64'd0);
    ptr = N - 1;
    repeat (30) @(negedge aud_ck);

`ifdef AUD_RMM_ARB_TIMEOUT_EN
    // Engine never answers: watchdog abort.
    f_we[0] = 1'b0; f_size[0] = 2'd2; f_addr[0] = 32'h3000; e_dly[0] = -1;
    run_round(4'b0001);
`endif

    repeat (40) begin
      for (int i = 0; i < N; i++) rand_fields(i);
      run_round(4'($urandom_range(1, (1 << N) - 1)));
    end

    repeat (5) @(negedge aud_ck);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
